l2_line_mem_model: RTL and testbench

- Parametrised, synthesizable line-granular backing memory that answers L2 data-cache refill and writeback requests.
- Sits below the L2_Data_Cache_Controller memory port and replaces the fixed 3-cycle, single-outstanding memory.
- Adds configurable latency, multiple outstanding requests queued in order, response backpressure, write acknowledges and out-of-range error reporting.

---
 rtl/l2_mem_pkg.sv | 20 ++
 rtl/l2_mem_req_queue.sv | 85 ++++++++
 rtl/l2_line_mem_model.sv | 100 ++++++++++
 tb/tb_l2_line_mem_model.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_pkg.sv
// Shared types for the L2 line backing memory: line word, queue entry, address helper.
package l2_mem_pkg;

   localparam int LINE_SIZE_DEF = 64;
   localparam int AGE_W         = 8;

   typedef logic [LINE_SIZE_DEF*8-1:0] line_t;

   typedef struct packed {
      logic             we;
      logic             err;
      line_t            data;
      logic [AGE_W-1:0] age;
   } mem_entry_t;

   function automatic logic [63:0] line_index(input logic [63:0] addr, input int off_bits);
      return addr >> off_bits;
   endfunction

endpackage

// File: rtl/l2_mem_req_queue.sv
// In-order response FIFO; each slot carries an age counter saturating at LATENCY.
module l2_mem_req_queue
   import l2_mem_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  mem_entry_t push_entry,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic       head_ready,
   output logic       nxt_ready,
   output logic       nxt_we,
   output logic       nxt_err,
   output line_t      nxt_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AGE_W-1:0] LAT = AGE_W'(LATENCY);

   mem_entry_t       slots [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr, nh;
   logic [CW-1:0]    cnt, remain;
   mem_entry_t       nxt_head;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
      return (a >= LAT) ? LAT : a + 1'b1;
   endfunction

   assign full       = (cnt == CW'(DEPTH));
   assign empty      = (cnt == '0);
   assign head_ready = !empty && (slots[rd_ptr].age == LAT);

   // Head as it will look after this edge; the top registers it so outputs stay flopped.
   assign nh     = pop ? inc(rd_ptr) : rd_ptr;
   assign remain = cnt - CW'(pop);

   always_comb begin
      nxt_head  = '0;
      nxt_ready = 1'b0;
      if (remain != '0) begin
         nxt_head     = slots[nh];
         nxt_head.age = sat_inc(slots[nh].age);
         nxt_ready    = (nxt_head.age == LAT);
      end
   end

   assign nxt_we   = nxt_head.we;
   assign nxt_err  = nxt_head.err;
   assign nxt_data = nxt_head.data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) slots[i].age <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) slots[i].age <= sat_inc(slots[i].age);
         if (push) begin
            slots[wr_ptr]     <= push_entry;
            slots[wr_ptr].age <= '0;
            wr_ptr            <= inc(wr_ptr);
         end
         if (pop) rd_ptr <= inc(rd_ptr);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
   a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
   a_params:        assert property (@(posedge clk)
                       (LATENCY >= 1) && (LATENCY < 2**AGE_W) && (DEPTH >= 1) &&
                       ((DEPTH & (DEPTH - 1)) == 0));

endmodule

// File: rtl/l2_line_mem_model.sv
// Line-granular backing memory for L2 refills/writebacks with latency, queueing and backpressure.
module l2_line_mem_model
   import l2_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_SIZE   = 64,
   parameter int MEM_LINES   = 1024,
   parameter int LATENCY     = 3,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mem_req,
   input  logic                   mem_we,
   input  logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic [LINE_SIZE*8-1:0] mem_write_data,
   output logic                   mem_ready,
   output logic                   mem_data_valid,
   output logic [LINE_SIZE*8-1:0] mem_read_data,
   output logic                   mem_resp_we,
   output logic                   mem_resp_err,
   input  logic                   mem_resp_ready
);

   localparam int LW  = LINE_SIZE * 8;
   localparam int OFF = $clog2(LINE_SIZE);
   localparam int IW  = $clog2(MEM_LINES);

   // Zeroed at time 0 only; reset deliberately leaves contents alone.
   logic [LW-1:0] mem [MEM_LINES] = '{default: '0};

   logic [63:0]   idx_full;
   logic [IW-1:0] idx;
   logic          addr_err, accept, pop;
   logic [LW-1:0] rd_line;
   mem_entry_t    push_entry;
   logic          q_full, q_empty, q_head_ready;
   logic          q_nxt_ready, q_nxt_we, q_nxt_err;
   line_t         q_nxt_data;

   assign idx_full  = line_index(64'(mem_addr), OFF);
   assign addr_err  = (idx_full >= 64'(MEM_LINES));
   assign idx       = idx_full[IW-1:0];
   assign rd_line   = mem[idx];

   assign mem_ready = !q_full;
   assign accept    = mem_req && mem_ready;
   assign pop       = mem_data_valid && mem_resp_ready;

   // Reads snapshot the line at accept, so they see every earlier-committed write.
   always_comb begin
      push_entry      = '0;
      push_entry.we   = mem_we;
      push_entry.err  = addr_err;
      push_entry.data = (mem_we || addr_err) ? '0 : rd_line;
   end

   always_ff @(posedge clk) begin
      if (rst_n && accept && mem_we && !addr_err) mem[idx] <= mem_write_data;
   end

   l2_mem_req_queue #(
      .DEPTH   (QUEUE_DEPTH),
      .LATENCY (LATENCY)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (pop),
      .full       (q_full),
      .empty      (q_empty),
      .head_ready (q_head_ready),
      .nxt_ready  (q_nxt_ready),
      .nxt_we     (q_nxt_we),
      .nxt_err    (q_nxt_err),
      .nxt_data   (q_nxt_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_data_valid <= 1'b0;
         mem_resp_we    <= 1'b0;
         mem_resp_err   <= 1'b0;
         mem_read_data  <= '0;
      end else begin
         mem_data_valid <= q_nxt_ready;
         mem_resp_we    <= q_nxt_ready && q_nxt_we;
         mem_resp_err   <= q_nxt_ready && q_nxt_err;
         mem_read_data  <= q_nxt_ready ? q_nxt_data : '0;
      end
   end

   a_params:   assert property (@(posedge clk)
                  (LATENCY >= 1) && ((LINE_SIZE & (LINE_SIZE - 1)) == 0) &&
                  (LW == $bits(line_t)) && (MEM_LINES >= 2) && (ADDR_WIDTH <= 64));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !q_empty);
   a_vld_head: assert property (@(posedge clk) disable iff (!rst_n) mem_data_valid == q_head_ready);

endmodule

// File: tb/tb_l2_line_mem_model.sv
// Bench for l2_line_mem_model: directed table, corner sequences, random traffic vs. a timestamp model.
module tb_l2_line_mem_model;
   import l2_mem_pkg::*;

   localparam int LAT = 3;
   localparam int QD  = 4;
   localparam int ML  = 1024;

   logic        clk = 1'b0;
   logic        rst_n, mem_req, mem_we, mem_ready, mem_data_valid;
   logic        mem_resp_we, mem_resp_err, mem_resp_ready;
   logic [31:0] mem_addr;
   line_t       mem_write_data, mem_read_data;

   l2_line_mem_model #(
      .ADDR_WIDTH(32), .LINE_SIZE(64), .MEM_LINES(ML), .LATENCY(LAT), .QUEUE_DEPTH(QD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_data_valid(mem_data_valid),
      .mem_read_data(mem_read_data), .mem_resp_we(mem_resp_we), .mem_resp_err(mem_resp_err),
      .mem_resp_ready(mem_resp_ready)
   );

   always #5 clk = ~clk;

   int nchk = 0, npass = 0;

   function automatic void chk1(input string nm, input logic act, input logic exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %b want %b", nm, act, exp);
   endfunction

   function automatic void chki(input string nm, input int act, input int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endfunction

   function automatic void chkl(input string nm, input line_t act, input line_t exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endfunction

   function automatic line_t pat(input logic [7:0] b);
      return {64{b}};
   endfunction

   // Reference: each response becomes visible once its accept edge + LAT has passed and it heads the queue.
   typedef struct { logic we; logic err; line_t data; int e; } rsp_t;
   rsp_t        mq[$];
   line_t       mmem [int];
   int          ecnt = 0;
   bit          m_acc, m_pop, m_exp_v;
   logic [63:0] m_li;
   rsp_t        m_r;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         ecnt++;
         #1;
         chk1("rst_valid", mem_data_valid, 1'b0);
         chk1("rst_we", mem_resp_we, 1'b0);
         chk1("rst_err", mem_resp_err, 1'b0);
         chkl("rst_data", mem_read_data, '0);
         chk1("rst_ready", mem_ready, 1'b1);
      end else begin
         m_pop = (mq.size() > 0) && (ecnt >= mq[0].e) && mem_resp_ready;
         m_acc = mem_req && (mq.size() < QD);
         ecnt++;
         if (m_pop) void'(mq.pop_front());
         if (m_acc) begin
            m_li    = 64'(mem_addr) / 64;
            m_r.we  = mem_we;
            m_r.err = (m_li >= ML);
            m_r.e   = ecnt + LAT;
            m_r.data = '0;
            if (!mem_we && !m_r.err && mmem.exists(int'(m_li))) m_r.data = mmem[int'(m_li)];
            if (mem_we && !m_r.err) mmem[int'(m_li)] = mem_write_data;
            mq.push_back(m_r);
         end
         #1;
         m_exp_v = (mq.size() > 0) && (ecnt >= mq[0].e);
         chk1("mon_ready", mem_ready, mq.size() < QD);
         chk1("mon_valid", mem_data_valid, m_exp_v);
         if (m_exp_v && mem_data_valid) begin
            chk1("mon_we", mem_resp_we, mq[0].we);
            chk1("mon_err", mem_resp_err, mq[0].err);
            chkl("mon_data", mem_read_data, mq[0].data);
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] a, input line_t d);
      int n = 0;
      mem_req = 1'b1; mem_we = we; mem_addr = a; mem_write_data = d;
      while (!mem_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chki("issue_timeout", n, 0);
      @(negedge clk);
      mem_req = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!mem_data_valid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chki("resp_timeout", n, 0);
   endtask

   task automatic take(output logic we, output logic err, output line_t d);
      int n;
      wait_valid(n);
      we = mem_resp_we; err = mem_resp_err; d = mem_read_data;
      @(negedge clk);
   endtask

   typedef struct {
      logic we; logic [31:0] addr; line_t wdata;
      logic exp_we; logic exp_err; line_t exp_data;
   } vec_t;
   vec_t vt [8];

   initial begin
      int    n;
      logic  rwe, rerr;
      line_t rd;

      vt[0] = '{1'b1, 32'h0000_1000, pat(8'hA5), 1'b1, 1'b0, '0};
      vt[1] = '{1'b0, 32'h0000_1000, '0,         1'b0, 1'b0, pat(8'hA5)};
      vt[2] = '{1'b0, 32'h0001_0000, '0,         1'b0, 1'b1, '0};
      vt[3] = '{1'b1, 32'h0001_0000, pat(8'h3C), 1'b1, 1'b1, '0};
      vt[4] = '{1'b0, 32'h0000_0000, '0,         1'b0, 1'b0, '0};
      vt[5] = '{1'b1, 32'h0000_FFC0, pat(8'h5A), 1'b1, 1'b0, '0};
      vt[6] = '{1'b0, 32'h0000_FFFF, '0,         1'b0, 1'b0, pat(8'h5A)};
      vt[7] = '{1'b0, 32'hFFFF_FFC0, '0,         1'b0, 1'b1, '0};

      rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
      mem_write_data = '0; mem_resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         issue(vt[i].we, vt[i].addr, vt[i].wdata);
         take(rwe, rerr, rd);
         chk1($sformatf("vec%0d_we", i), rwe, vt[i].exp_we);
         chk1($sformatf("vec%0d_err", i), rerr, vt[i].exp_err);
         chkl($sformatf("vec%0d_data", i), rd, vt[i].exp_data);
      end

      // Write then read back-to-back: ack after LATENCY, read one cycle later.
      issue(1'b1, 32'h1000, pat(8'hA5));
      issue(1'b0, 32'h1000, '0);
      wait_valid(n);
      chki("a_ack_lat", n, 2);
      chk1("a_ack_we", mem_resp_we, 1'b1);
      @(negedge clk);
      chk1("a_rd_valid", mem_data_valid, 1'b1);
      chk1("a_rd_we", mem_resp_we, 1'b0);
      chkl("a_rd_data", mem_read_data, pat(8'hA5));
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 32'(i * 64), pat(8'(8'h10 + i)));
         take(rwe, rerr, rd);
      end

      // Four streaming reads: full throughput, in order.
      for (int i = 0; i < 4; i++) begin
         chk1("b_ready", mem_ready, 1'b1);
         mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'(i * 64);
         @(negedge clk);
      end
      mem_req = 1'b0;
      wait_valid(n);
      chki("b_first_lat", n, 0);
      for (int i = 0; i < 4; i++) begin
         chk1("b_valid", mem_data_valid, 1'b1);
         chkl("b_data", mem_read_data, pat(8'(8'h10 + i)));
         @(negedge clk);
      end
      chk1("b_idle", mem_data_valid, 1'b0);

      // Backpressure: queue fills, head holds, extra request ignored, drain in order.
      mem_resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(1'b0, 32'(i * 64), '0);
      chk1("c_full_ready", mem_ready, 1'b0);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
      for (int i = 0; i < 5; i++) begin
         chk1("c_hold_valid", mem_data_valid, 1'b1);
         chkl("c_hold_data", mem_read_data, pat(8'h10));
         chk1("c_hold_ready", mem_ready, 1'b0);
         @(negedge clk);
      end
      mem_req = 1'b0;
      mem_resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk1("c_drain_valid", mem_data_valid, 1'b1);
         chkl("c_drain_data", mem_read_data, pat(8'(8'h10 + i)));
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk1("c_no_extra", mem_data_valid, 1'b0);

      // Read-before-write ordering on the same line.
      issue(1'b0, 32'h100, '0);
      issue(1'b1, 32'h100, {16{32'hDEADBEEF}});
      issue(1'b0, 32'h100, '0);
      take(rwe, rerr, rd);
      chk1("d_rd0_we", rwe, 1'b0);
      chkl("d_rd0_data", rd, '0);
      take(rwe, rerr, rd);
      chk1("d_wr_we", rwe, 1'b1);
      chkl("d_wr_data", rd, '0);
      take(rwe, rerr, rd);
      chk1("d_rd1_we", rwe, 1'b0);
      chkl("d_rd1_data", rd, {16{32'hDEADBEEF}});

      // Reset with pending responses: all dropped, array survives.
      mem_resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(1'b0, 32'(i * 64), '0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk1("f_no_valid", mem_data_valid, 1'b0);
         chk1("f_ready", mem_ready, 1'b1);
         @(negedge clk);
      end
      issue(1'b0, 32'h1000, '0);
      take(rwe, rerr, rd);
      chkl("f_persist", rd, pat(8'hA5));

      // Random traffic; the monitor model checks every cycle.
      for (int c = 0; c < 600; c++) begin
         logic [10:0] ln;
         line_t       d;
         ln = ($urandom_range(0, 7) == 0) ? 11'(1016 + $urandom_range(0, 15)) : 11'($urandom_range(0, 7));
         for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
         mem_req        = ($urandom_range(0, 2) != 0);
         mem_we         = $urandom_range(0, 1) == 1;
         mem_addr       = {15'b0, ln, 6'($urandom)};
         mem_write_data = d;
         mem_resp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      mem_req = 1'b0;
      mem_resp_ready = 1'b1;
      repeat (30) @(negedge clk);
      chki("end_drained", mq.size(), 0);
      chk1("end_idle", mem_data_valid, 1'b0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
